// File: rtl/cpu_pkg.sv
// Shared opcode, FSM-state and instruction-field definitions for the pipeline
// stage tracker.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_ATYPE = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_LBU   = 4'b0100,
        OP_SB    = 4'b0101,
        OP_LW    = 4'b0110,
        OP_SW    = 4'b0111,
        OP_JMP   = 4'b1000,
        OP_BLT   = 4'b1100,
        OP_BGT   = 4'b1101,
        OP_BEQ   = 4'b1110,
        OP_HALT  = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OP1_MSB = 11;
    localparam int OP1_LSB = 8;
    localparam int OP2_MSB = 7;
    localparam int OP2_LSB = 4;
    localparam int FN_MSB  = 3;
    localparam int FN_LSB  = 0;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] dest;
        logic [3:0] funct;
    } stage_t;

    function automatic logic is_load(input logic [3:0] opc);
        return (opc == OP_LW) || (opc == OP_LBU);
    endfunction

endpackage

// File: rtl/pipe_stage_tracker_if.sv
// Fetch/flush inputs and per-stage status outputs of the pipeline stage tracker.
interface pipe_stage_tracker_if #(
    parameter int IW = 16
);
    logic [IW-1:0] InstrIF;
    logic          BranchTaken;
    logic          Jump;
    logic [IW-1:0] InstrID;
    logic [3:0]    OpcodeID;
    logic [3:0]    OpcodeEX;
    logic [3:0]    OpcodeMEM;
    logic [3:0]    OpcodeWB;
    logic [3:0]    FunctionCode;
    logic [3:0]    DestEX;
    logic [3:0]    DestMEM;
    logic [3:0]    DestWB;
    logic          PCWrite;
    logic          Stall;
    logic          Halted;

    modport master (
        output InstrIF, BranchTaken, Jump,
        input  InstrID, OpcodeID, OpcodeEX, OpcodeMEM, OpcodeWB, FunctionCode,
        input  DestEX, DestMEM, DestWB, PCWrite, Stall, Halted
    );

    modport slave (
        input  InstrIF, BranchTaken, Jump,
        output InstrID, OpcodeID, OpcodeEX, OpcodeMEM, OpcodeWB, FunctionCode,
        output DestEX, DestMEM, DestWB, PCWrite, Stall, Halted
    );
endinterface

// File: rtl/stage_reg.sv
// One pipeline stage register: loads the upstream value, holds, or takes a bubble
// (bubble wins over hold).
module stage_reg #(
    parameter int           W      = 12,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_bubble_i,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next-state selection
    always_comb begin
        data_d = data_q;
        if (load_bubble_i) begin
            data_d = BUBBLE;
        end else if (hold_i) begin
            data_d = data_q;
        end else begin
            data_d = d_i;
        end
    end

    // Stage storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= BUBBLE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_tracker.sv
// Tracks the instruction in each stage of a four-stage pipeline, inserting
// load-use bubbles, flushing on branch/jump and draining on HALT.
module pipe_stage_tracker
    import cpu_pkg::*;
#(
    parameter int         IW     = 16,
    parameter logic [3:0] NOP_OP = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_stage_tracker_if.slave  bus
);
    localparam logic [IW-1:0] ID_BUBBLE    = {NOP_OP, {(IW-4){1'b0}}};
    localparam stage_t        STAGE_BUBBLE = '{opcode: NOP_OP, dest: 4'h0, funct: 4'h0};

    logic [IW-1:0] id_q;
    stage_t        ex_q;
    stage_t        mem_q;
    stage_t        wb_q;
    stage_t        id_fields_s;
    state_e        state_q;
    logic          halted_q;

    logic [3:0] id_opc_s;
    logic [3:0] id_op1_s;
    logic [3:0] id_op2_s;
    logic [3:0] id_fn_s;
    logic       stall_s;
    logic       flush_s;
    logic       halt_req_s;
    logic       drained_s;
    logic       clear_all_s;
    logic       id_bubble_s;
    logic       ex_bubble_s;

    assign id_opc_s    = id_q[OPC_MSB:OPC_LSB];
    assign id_op1_s    = id_q[OP1_MSB:OP1_LSB];
    assign id_op2_s    = id_q[OP2_MSB:OP2_LSB];
    assign id_fn_s     = id_q[FN_MSB:FN_LSB];
    assign id_fields_s = '{opcode: id_opc_s, dest: id_op1_s, funct: id_fn_s};

    assign stall_s = is_load(ex_q.opcode)
                   && ((ex_q.dest == id_op1_s) || (ex_q.dest == id_op2_s))
                   && (id_opc_s != NOP_OP);

    // A stalled cycle ignores control transfers so the held ID instruction survives.
    assign flush_s     = (bus.BranchTaken || bus.Jump) && !stall_s;
    assign halt_req_s  = (state_q == ST_RUN) && (id_opc_s == OP_HALT) && !stall_s;
    assign drained_s   = ((ex_q.opcode  == NOP_OP) || (ex_q.opcode  == OP_HALT))
                      && ((mem_q.opcode == NOP_OP) || (mem_q.opcode == OP_HALT))
                      && ((wb_q.opcode  == NOP_OP) || (wb_q.opcode  == OP_HALT));
    assign clear_all_s = (state_q == ST_HALTED) || ((state_q == ST_DRAIN) && drained_s);
    assign id_bubble_s = clear_all_s || (state_q == ST_DRAIN) || halt_req_s || flush_s;
    assign ex_bubble_s = stall_s || clear_all_s;

    stage_reg #(.W(IW), .BUBBLE(ID_BUBBLE)) u_id (
        .clk(clk), .reset(reset), .load_bubble_i(id_bubble_s), .hold_i(stall_s),
        .d_i(bus.InstrIF), .q_o(id_q)
    );

    stage_reg #(.W($bits(stage_t)), .BUBBLE(STAGE_BUBBLE)) u_ex (
        .clk(clk), .reset(reset), .load_bubble_i(ex_bubble_s), .hold_i(1'b0),
        .d_i(id_fields_s), .q_o(ex_q)
    );

    stage_reg #(.W($bits(stage_t)), .BUBBLE(STAGE_BUBBLE)) u_mem (
        .clk(clk), .reset(reset), .load_bubble_i(clear_all_s), .hold_i(1'b0),
        .d_i(ex_q), .q_o(mem_q)
    );

    stage_reg #(.W($bits(stage_t)), .BUBBLE(STAGE_BUBBLE)) u_wb (
        .clk(clk), .reset(reset), .load_bubble_i(clear_all_s), .hold_i(1'b0),
        .d_i(mem_q), .q_o(wb_q)
    );

    // Run/drain/halt control; HALTED only leaves through reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req_s) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained_s) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q  <= ST_HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InstrID      = id_q;
    assign bus.OpcodeID     = id_opc_s;
    assign bus.OpcodeEX     = ex_q.opcode;
    assign bus.OpcodeMEM    = mem_q.opcode;
    assign bus.OpcodeWB     = wb_q.opcode;
    assign bus.FunctionCode = wb_q.funct;
    assign bus.DestEX       = ex_q.dest;
    assign bus.DestMEM      = mem_q.dest;
    assign bus.DestWB       = wb_q.dest;
    assign bus.PCWrite      = (state_q == ST_RUN) && !stall_s;
    assign bus.Stall        = stall_s;
    assign bus.Halted       = halted_q;
endmodule

// File: tb/tb_pipe_stage_tracker.sv
// Directed bench for pipe_stage_tracker: hazards, flushes, halt drain and
// asynchronous reset, with hand-computed expectations.
module tb_pipe_stage_tracker;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    pipe_stage_tracker_if #(.IW(16)) bus();

    pipe_stage_tracker #(.IW(16), .NOP_OP(4'b0000)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic br, input logic jp);
        bus.InstrIF     = instr;
        bus.BranchTaken = br;
        bus.Jump        = jp;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_instr_id"}, bus.InstrID, 16'h0000);
        chk({tag, "_op_id"},  16'(bus.OpcodeID),  16'h0000);
        chk({tag, "_op_ex"},  16'(bus.OpcodeEX),  16'h0000);
        chk({tag, "_op_mem"}, 16'(bus.OpcodeMEM), 16'h0000);
        chk({tag, "_op_wb"},  16'(bus.OpcodeWB),  16'h0000);
        chk({tag, "_stall"},  16'(bus.Stall),     16'h0000);
        chk({tag, "_pcwrite"}, 16'(bus.PCWrite),  16'h0001);
        chk({tag, "_halted"}, 16'(bus.Halted),    16'h0000);
    endtask

    initial begin
        reset = 1'b1;
        drive(16'h0000, 1'b0, 1'b0);
        #12;
        check_cleared("reset");
        @(negedge clk);
        reset = 1'b0;

        // ADD then SUB flowing to WB
        drive(16'h1123, 1'b0, 1'b0);
        tick();
        chk("add_in_id", bus.InstrID, 16'h1123);
        chk("add_stall0", 16'(bus.Stall), 16'h0000);
        drive(16'h1456, 1'b0, 1'b0);
        tick();
        chk("add_op_ex", 16'(bus.OpcodeEX), 16'h0001);
        chk("add_dest_ex", 16'(bus.DestEX), 16'h0001);
        chk("sub_stall0", 16'(bus.Stall), 16'h0000);
        drive(16'h0000, 1'b0, 1'b0);
        tick();
        chk("add_dest_mem", 16'(bus.DestMEM), 16'h0001);
        tick();
        chk("add_op_wb", 16'(bus.OpcodeWB), 16'h0001);
        chk("add_funct_wb", 16'(bus.FunctionCode), 16'h0003);
        chk("add_dest_wb", 16'(bus.DestWB), 16'h0001);
        tick();
        chk("sub_op_wb", 16'(bus.OpcodeWB), 16'h0001);
        chk("sub_funct_wb", 16'(bus.FunctionCode), 16'h0006);
        chk("sub_dest_wb", 16'(bus.DestWB), 16'h0004);

        // LW R3 then a reader of R3: one bubble
        drive(16'h6310, 1'b0, 1'b0);
        tick();
        chk("lw_pre_stall", 16'(bus.Stall), 16'h0000);
        drive(16'h1345, 1'b0, 1'b0);
        tick();
        chk("lw_stall1", 16'(bus.Stall), 16'h0001);
        chk("lw_pcwrite0", 16'(bus.PCWrite), 16'h0000);
        drive(16'h2000, 1'b0, 1'b0);
        tick();
        chk("lw_bubble_ex", 16'(bus.OpcodeEX), 16'h0000);
        chk("lw_id_held", bus.InstrID, 16'h1345);
        chk("lw_mem_adv", 16'(bus.OpcodeMEM), 16'h0006);
        chk("lw_stall_once", 16'(bus.Stall), 16'h0000);
        chk("lw_pcwrite1", 16'(bus.PCWrite), 16'h0001);
        drive(16'h0000, 1'b0, 1'b0);
        tick();
        chk("lw_user_ex", 16'(bus.OpcodeEX), 16'h0001);

        // BEQ taken flushes the fetched 0x1777
        drive(16'hE120, 1'b0, 1'b0);
        tick();
        chk("beq_in_id", 16'(bus.OpcodeID), 16'h000E);
        drive(16'h1777, 1'b1, 1'b0);
        tick();
        chk("beq_flush_id", 16'(bus.OpcodeID), 16'h0000);
        chk("beq_flush_instr", bus.InstrID, 16'h0000);
        chk("beq_in_ex", 16'(bus.OpcodeEX), 16'h000E);
        drive(16'h0000, 1'b0, 1'b0);
        tick();
        chk("flushed_not_ex", 16'(bus.OpcodeEX), 16'h0000);
        chk("beq_in_mem", 16'(bus.OpcodeMEM), 16'h000E);

        // Jump flushes a HALT in fetch; no drain follows
        drive(16'h8000, 1'b0, 1'b0);
        tick();
        drive(16'hF000, 1'b0, 1'b1);
        tick();
        chk("jmp_flush_halt", 16'(bus.OpcodeID), 16'h0000);
        chk("jmp_in_ex", 16'(bus.OpcodeEX), 16'h0008);
        drive(16'h0000, 1'b0, 1'b0);
        tick();
        chk("jmp_no_drain_pc", 16'(bus.PCWrite), 16'h0001);
        chk("jmp_no_halt", 16'(bus.Halted), 16'h0000);

        // Load-use stall with BranchTaken: flush suppressed
        drive(16'h6510, 1'b0, 1'b0);
        tick();
        drive(16'h1450, 1'b0, 1'b0);
        tick();
        drive(16'h2222, 1'b1, 1'b0);
        #1;
        chk("lwbr_stall", 16'(bus.Stall), 16'h0001);
        chk("lwbr_pcwrite0", 16'(bus.PCWrite), 16'h0000);
        tick();
        chk("lwbr_id_kept", bus.InstrID, 16'h1450);
        chk("lwbr_bubble_ex", 16'(bus.OpcodeEX), 16'h0000);
        drive(16'h0000, 1'b0, 1'b0);
        tick();
        chk("lwbr_user_ex", 16'(bus.OpcodeEX), 16'h0001);

        // LBU stall, then asynchronous reset mid-stall
        drive(16'h4710, 1'b0, 1'b0);
        tick();
        drive(16'h1070, 1'b0, 1'b0);
        tick();
        chk("lbu_stall1", 16'(bus.Stall), 16'h0001);
        #2;
        reset = 1'b1;
        drive(16'h1123, 1'b0, 1'b0);
        #1;
        check_cleared("rst_stall");
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("first_edge_capture", bus.InstrID, 16'h1123);

        // ADD then HALT: drain, halt and stay halted
        drive(16'hF000, 1'b0, 1'b0);
        tick();
        chk("halt_in_id_pc1", 16'(bus.PCWrite), 16'h0001);
        drive(16'h1999, 1'b0, 1'b0);
        tick();
        chk("drain_pc0", 16'(bus.PCWrite), 16'h0000);
        chk("drain_id_nop", 16'(bus.OpcodeID), 16'h0000);
        chk("drain_halt_ex", 16'(bus.OpcodeEX), 16'h000F);
        chk("drain_not_halted", 16'(bus.Halted), 16'h0000);
        tick();
        chk("drain_add_wb", 16'(bus.OpcodeWB), 16'h0001);
        chk("drain_add_halted0", 16'(bus.Halted), 16'h0000);
        chk("drain_pc0b", 16'(bus.PCWrite), 16'h0000);
        tick();
        tick();
        chk("halted1", 16'(bus.Halted), 16'h0001);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_halted", 16'(bus.Halted), 16'h0001);
            chk("hold_pc0", 16'(bus.PCWrite), 16'h0000);
            chk("hold_id_nop", 16'(bus.OpcodeID), 16'h0000);
            chk("hold_ex_nop", 16'(bus.OpcodeEX), 16'h0000);
            chk("hold_wb_nop", 16'(bus.OpcodeWB), 16'h0000);
        end

        // Reset out of HALTED, then again in the middle of DRAIN
        #2;
        reset = 1'b1;
        drive(16'h1123, 1'b0, 1'b0);
        #1;
        check_cleared("rst_halted");
        @(negedge clk);
        reset = 1'b0;
        tick();
        drive(16'hF000, 1'b0, 1'b0);
        tick();
        drive(16'h1999, 1'b0, 1'b0);
        tick();
        chk("drain2_pc0", 16'(bus.PCWrite), 16'h0000);
        #2;
        reset = 1'b1;
        drive(16'h1456, 1'b0, 1'b0);
        #1;
        check_cleared("rst_drain");
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_drain_capture", bus.InstrID, 16'h1456);
        chk("post_drain_pc1", 16'(bus.PCWrite), 16'h0001);
        chk("post_drain_halted0", 16'(bus.Halted), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_tracker.md
PIPE_STAGE_TRACKER -- requirements
Module: pipe_stage_tracker

Interface
REQ-001 Parameter IW, default 16, instruction width; fields are opcode [15:12], op1/dest [11:8], op2 [7:4], funct [3:0].
REQ-002 Parameter NOP_OP, default 4'b0000, bubble opcode injected on stall or flush.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 InstrIF  input  IW  instruction fetched this cycle.
REQ-006 BranchTaken  input  1  branch in ID resolved taken.
REQ-007 Jump  input  1  jump in ID.
REQ-008 InstrID  output  IW  IF/ID register contents.
REQ-009 OpcodeID, OpcodeEX, OpcodeMEM, OpcodeWB  output  4 each  opcode held in each stage.
REQ-010 FunctionCode  output  4  funct field of the WB-stage instruction.
REQ-011 DestEX, DestMEM, DestWB  output  4 each  op1 field per stage, used for forwarding.
REQ-012 PCWrite  output  1  0 = hold PC.
REQ-013 Stall  output  1  load-use bubble inserted this cycle.
REQ-014 Halted  output  1  processor halted and pipeline drained.

Function
REQ-015 Each stage register (ID, EX, MEM, WB) SHALL hold the opcode, op1 and funct fields of its instruction; the EX, MEM and WB registers advance one stage per cycle with no internal latency.
REQ-016 Stall SHALL be combinational 1 when OpcodeEX is 4'b0110 (LW) or 4'b0100 (LBU), and DestEX equals op1 or op2 of InstrID, and OpcodeID is not NOP_OP.
REQ-017 On Stall, the ID register and PC SHALL hold (PCWrite=0), EX SHALL load NOP_OP with fields 0, and MEM and WB SHALL advance normally.
REQ-018 When (BranchTaken|Jump)=1 and Stall=0, the ID register SHALL load NOP_OP with fields 0 in place of InstrIF, and EX SHALL receive the branch or jump normally.
REQ-019 Stall SHALL take priority: BranchTaken and Jump SHALL be ignored in any cycle with Stall=1.
REQ-020 FSM states: RUN, DRAIN, HALTED; reset state is RUN.
REQ-021 RUN->DRAIN when OpcodeID==4'b1111 (HALT) and Stall=0; from that edge on, ID SHALL load NOP_OP and PCWrite SHALL be 0.
REQ-022 DRAIN->HALTED when OpcodeEX, OpcodeMEM and OpcodeWB are all NOP_OP or HALT.
REQ-023 HALTED is terminal until reset; in it all stages hold NOP_OP, PCWrite=0 and Halted=1.
REQ-024 A HALT that arrives in ID together with BranchTaken or Jump from the previous instruction SHALL NOT occur, because the flush of REQ-018 removes it; the bench SHALL confirm this.
REQ-025 PCWrite SHALL be 1 only in RUN with Stall=0.

Reset
REQ-026 While reset is high, all stage registers SHALL be NOP_OP with fields 0, FSM=RUN, and outputs SHALL be InstrID=0, Stall=0, PCWrite=1, Halted=0.
REQ-027 Reset asserted mid-stall or during DRAIN SHALL abort the operation immediately with no residual bubble or held instruction.
REQ-028 On the first edge after reset deassertion, ID SHALL capture InstrIF.

Structure
REQ-029 Opcode constants (NOP 0000, ATYPE 0001, AND 0010, OR 0011, LBU 0100, SB 0101, LW 0110, SW 0111, JMP 1000, BLT 1100, BGT 1101, BEQ 1110, HALT 1111), the FSM state enum and the field bit positions SHALL reside in the shared package cpu_pkg.
REQ-030 One sub-module, stage_reg (a per-stage opcode/dest/funct register with load-bubble and hold controls), SHALL be instantiated once per stage.

Verification
REQ-031 Sequence ADD 0x1123, SUB 0x1456 -> OpcodeWB=0001 four edges after each instruction's fetch; FunctionCode=3 then 6; Stall never 1.
REQ-032 LW 0x6310 followed by 0x1345 (reads R3) -> Stall=1 for exactly 1 cycle; PCWrite=0; OpcodeEX=0000 that cycle; OpcodeEX=0001 on the next edge.
REQ-033 BEQ in ID with BranchTaken=1 and InstrIF=0x1777 -> OpcodeID=0000 next cycle; 0x1777 never reaches EX.
REQ-034 HALT 0xF000 following ADD -> PCWrite=0 from the DRAIN edge; Halted=1 once the ADD clears WB; state held for 10 further cycles.
REQ-035 LW load-use stall together with BranchTaken=1 -> flush suppressed; ID retains its instruction.
REQ-036 Reset pulsed in DRAIN and mid-stall -> all opcodes=0000, Halted=0, PCWrite=1 asynchronously, with no clock edge required.
